// File: rtl/count_pkg.sv
// Shared types and helpers for the parametrised up/down counter.
package count_pkg;

    localparam int unsigned MODE_W = 2;

    // Operating mode of the counter; also driven out as the registered state.
    typedef enum logic [MODE_W-1:0] {
        HOLD = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        LOAD = 2'd3
    } mode_e;

    // Clamp value into [lo, hi]; used for out-of-range load data.
    function automatic int unsigned range_clamp(input int unsigned value,
                                                input int unsigned lo,
                                                input int unsigned hi);
        if (value < lo) begin
            return lo;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/count_limit_step.sv
// Combinational next-value and terminal-count logic for updown_counter_n.
// Works in WIDTH+2 bits so q+step / q-step never overflow before the limit compare.
module count_limit_step
    import count_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STEP_W   = 4,
    parameter int unsigned MIN_VAL  = 0,
    parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
    parameter int unsigned SATURATE = 0
) (
    input  logic [WIDTH-1:0]  q_i,
    input  logic [STEP_W-1:0] step_i,
    input  mode_e             mode_i,
    output logic [WIDTH-1:0]  q_next_o,
    output logic              tc_up_o,
    output logic              tc_dn_o,
    output logic              crossed_o
);

    localparam int unsigned EXT_W = WIDTH + 2;
    localparam logic [EXT_W-1:0] MIN_EXT  = EXT_W'(MIN_VAL);
    localparam logic [EXT_W-1:0] MAX_EXT  = EXT_W'(MAX_VAL);
    localparam logic [EXT_W-1:0] ONE_EXT  = EXT_W'(1);
    localparam logic [EXT_W-1:0] SPAN_EXT = MAX_EXT - MIN_EXT + ONE_EXT;

    logic [EXT_W-1:0] q_ext;
    logic [EXT_W-1:0] step_ext;
    logic [EXT_W-1:0] step_eff;
    logic [EXT_W-1:0] sum;
    logic [EXT_W-1:0] floor_v;

    assign q_ext    = EXT_W'(q_i);
    assign step_ext = EXT_W'(step_i);
    // An oversized step is cut down to one full trip round the range.
    assign step_eff = (step_ext > SPAN_EXT) ? SPAN_EXT : step_ext;
    assign sum      = q_ext + step_eff;
    // q - step >= MIN_VAL is rewritten as q >= MIN_VAL + step to stay unsigned.
    assign floor_v  = MIN_EXT + step_eff;

    // Next count value, limit handling and terminal-count flags for the decoded mode.
    always_comb begin
        q_next_o  = q_i;
        tc_up_o   = 1'b0;
        tc_dn_o   = 1'b0;
        crossed_o = 1'b0;
        if (step_eff != '0) begin
            case (mode_i)
                UP: begin
                    tc_up_o = (sum >= MAX_EXT);
                    if (sum <= MAX_EXT) begin
                        q_next_o = WIDTH'(sum);
                    end else begin
                        crossed_o = 1'b1;
                        if (SATURATE != 0) begin
                            q_next_o = WIDTH'(MAX_VAL);
                        end else begin
                            q_next_o = WIDTH'(sum - MAX_EXT - ONE_EXT + MIN_EXT);
                        end
                    end
                end
                DOWN: begin
                    tc_dn_o = (q_ext <= floor_v);
                    if (q_ext >= floor_v) begin
                        q_next_o = WIDTH'(q_ext - step_eff);
                    end else begin
                        crossed_o = 1'b1;
                        if (SATURATE != 0) begin
                            q_next_o = WIDTH'(MIN_VAL);
                        end else begin
                            // MAX - (MIN - (q - step) - 1), reordered to avoid negatives.
                            q_next_o = WIDTH'(MAX_EXT + q_ext + ONE_EXT - floor_v);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with range, runtime step, load, wrap/saturate
// and registered terminal-count pulses.
// Optional sticky overflow flag: define UPDOWN_COUNTER_N_STICKY_OVF_EN.
module updown_counter_n
    import count_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STEP_W   = 4,
    parameter int unsigned MIN_VAL  = 0,
    parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned RST_VAL  = MIN_VAL
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              dir_i,
    input  logic              load_i,
    input  logic [WIDTH-1:0]  d_i,
    input  logic [STEP_W-1:0] step_i,
`ifdef UPDOWN_COUNTER_N_STICKY_OVF_EN
    input  logic              ovf_clr_i,
    output logic              ovf_o,
`endif
    output mode_e             state_o,
    output logic [WIDTH-1:0]  q_o,
    output logic              tc_up_o,
    output logic              tc_dn_o
);

    localparam int unsigned SPAN = MAX_VAL - MIN_VAL + 1;

    mode_e            mode_d;
    mode_e            state_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_step;
    logic             tc_up_d;
    logic             tc_up_q;
    logic             tc_dn_d;
    logic             tc_dn_q;
    logic             limit_crossed;

    // Priority mode decode: load, then up, then down, else hold.
    always_comb begin
        mode_d = HOLD;
        if (load_i) begin
            mode_d = LOAD;
        end else if (en_i && dir_i) begin
            mode_d = UP;
        end else if (en_i) begin
            mode_d = DOWN;
        end
    end

    count_limit_step #(
        .WIDTH    (WIDTH),
        .STEP_W   (STEP_W),
        .MIN_VAL  (MIN_VAL),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_limit_step (
        .q_i       (q_q),
        .step_i    (step_i),
        .mode_i    (mode_d),
        .q_next_o  (q_step),
        .tc_up_o   (tc_up_d),
        .tc_dn_o   (tc_dn_d),
        .crossed_o (limit_crossed)
    );

    // Load bypasses the arithmetic path; out-of-range data clamps to the nearest limit.
    always_comb begin
        if (mode_d == LOAD) begin
            q_d = WIDTH'(range_clamp(32'(d_i), MIN_VAL, MAX_VAL));
        end else begin
            q_d = q_step;
        end
    end

    // Counter, mode and terminal-count registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q     <= WIDTH'(RST_VAL);
            state_q <= HOLD;
            tc_up_q <= 1'b0;
            tc_dn_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            state_q <= mode_d;
            tc_up_q <= tc_up_d;
            tc_dn_q <= tc_dn_d;
        end
    end

    assign q_o     = q_q;
    assign state_o = state_q;
    assign tc_up_o = tc_up_q;
    assign tc_dn_o = tc_dn_q;

`ifdef UPDOWN_COUNTER_N_STICKY_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Set on a wrap/saturate crossing; set beats a same-cycle clear.
    always_comb begin
        ovf_d = limit_crossed | (ovf_q & ~ovf_clr_i);
    end

    // Sticky overflow register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    logic unused_limit_crossed;
    assign unused_limit_crossed = limit_crossed;
`endif

    // A counting step larger than the range span is truncated by the datapath.
    step_in_span_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (en_i && !load_i) |-> (32'(step_i) <= SPAN));

endmodule
